encode_add_sched: RTL



---
 rtl/encode_add_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/encode_add_sched.sv
// Purpose: launches the encode unit, forwards its K writes, then streams K+V (mod q) into C RAM.
// Latency: ADD+DRAIN span NWORDS+1 cycles; C writes trail K/V reads by one cycle; done follows the last write.
// Backpressure: none; RAMs accept one access per cycle and the encoder is paced by its own done level.
module encode_add_sched #(
    parameter int T      = 4,
    parameter int WQ     = 16,
    parameter int NWORDS = 16,
    parameter int AW     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_sec_level,
    output logic              o_enc_start,
    input  logic              i_enc_wen,
    input  logic [AW-1:0]     i_enc_addr,
    input  logic [T*WQ-1:0]   i_enc_data,
    input  logic              i_enc_done,
    output logic              o_k_wen,
    output logic [AW-1:0]     o_k_addr,
    output logic [T*WQ-1:0]   o_k_wdata,
    output logic              o_k_ren,
    input  logic [T*WQ-1:0]   i_k_rdata,
    output logic              o_v_ren,
    output logic [AW-1:0]     o_v_addr,
    input  logic [T*WQ-1:0]   i_v_rdata,
    output logic              o_c_wen,
    output logic [AW-1:0]     o_c_addr,
    output logic [T*WQ-1:0]   o_c_wdata,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ENC,
        S_ADD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_lvl;
    logic            r_seen_low;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   r_waddr;
    logic            r_valid;
    logic            r_done;
    logic            r_busy;
    logic            r_enc_start;
    logic            w_mod15;
    logic [T*WQ-1:0] w_sum;

    // Level 3 and 5 use the full 16-bit lane; every other level code behaves as level 1 (mod 2^15).
    assign w_mod15 = !((r_lvl == 3'd3) || (r_lvl == 3'd5));

    // Control FSM plus the one-cycle read-to-write pipeline for the C RAM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_lvl       <= 3'd0;
            r_seen_low  <= 1'b0;
            r_rd_addr   <= '0;
            r_waddr     <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_enc_start <= 1'b0;
        end else begin
            r_enc_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_lvl       <= i_sec_level;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_enc_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Forget any done level from a previous run before watching for the new one.
                    r_seen_low <= 1'b0;
                    r_state    <= S_ENC;
                end
                S_ENC: begin
                    if (!i_enc_done) begin
                        r_seen_low <= 1'b1;
                    end
                    if (i_enc_done && r_seen_low) begin
                        r_rd_addr <= '0;
                        r_state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                    if (r_rd_addr == AW'(NWORDS - 1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
            r_valid <= (r_state == S_ADD);
            r_waddr <= r_rd_addr;
        end
    end

    // K port belongs to the encoder during ENC and to the read stream during ADD; idle otherwise.
    always_comb begin
        o_k_wen   = 1'b0;
        o_k_addr  = '0;
        o_k_wdata = '0;
        o_k_ren   = 1'b0;
        o_v_ren   = 1'b0;
        o_v_addr  = '0;
        case (r_state)
            S_ENC: begin
                o_k_wen   = i_enc_wen;
                o_k_addr  = i_enc_addr;
                o_k_wdata = i_enc_data;
            end
            S_ADD: begin
                o_k_ren  = 1'b1;
                o_v_ren  = 1'b1;
                o_k_addr = r_rd_addr;
                o_v_addr = r_rd_addr;
            end
            default: begin
            end
        endcase
    end

    // Lane-wise add with no inter-lane carry; the top bit is dropped for the 2^15 modulus.
    for (genvar j = 0; j < T; j++) begin : g_lane
        logic [WQ-1:0] w_raw;
        assign w_raw = i_k_rdata[j*WQ +: WQ] + i_v_rdata[j*WQ +: WQ];
        assign w_sum[j*WQ +: WQ] = {w_raw[WQ-1] & ~w_mod15, w_raw[WQ-2:0]};
    end

    assign o_enc_start = r_enc_start;
    assign o_c_wen     = r_valid;
    assign o_c_addr    = r_waddr;
    assign o_c_wdata   = w_sum;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
